seq_divider_16bit: RTL

//  Sequential unsigned restoring divider: quotient = dividend / divisor, remainder = dividend % divisor.

---
 rtl/seq_divider_16bit_pkg.sv | 14 +
 rtl/seq_divider_16bit_step.sv | 19 +
 rtl/seq_divider_16bit.sv | 85 ++++++++
 3 files changed

// File: rtl/seq_divider_16bit_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and default width.
package seq_divider_16bit_pkg;
  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/seq_divider_16bit_step.sv
// One restoring-division iteration: shift the next dividend bit into R and subtract the divisor.
module div_step_sub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-2:0] r_low,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_out,
  output logic             q_bit
);
  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   diff;

  // R < 2^(WIDTH-1) before every shift, so its msb never needs to enter the subtract
  assign shifted = {r_low, q_msb};
  assign diff    = {1'b0, shifted} - {1'b0, divisor};
  assign q_bit   = ~diff[WIDTH];
  assign r_out   = q_bit ? diff[WIDTH-1:0] : shifted;
endmodule

// File: rtl/seq_divider_16bit.sv
// Sequential unsigned divider: one quotient bit per clock, start/busy/done handshake.
module seq_divider_16bit
  import seq_divider_16bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = cnt_width(WIDTH);

  div_state_t       state;
  logic [WIDTH-1:0] r_q, q_q, d_q, r_nxt;
  logic [CW-1:0]    cnt;
  logic             dz_q, q_bit;

  div_step_sub #(.WIDTH(WIDTH)) u_step (
    .r_low   (r_q[WIDTH-2:0]),
    .q_msb   (q_q[WIDTH-1]),
    .divisor (d_q),
    .r_out   (r_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt         <= '0;
      dz_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy        <= 1'b1;
          d_q         <= divisor;
          cnt         <= CW'(WIDTH - 1);
          div_by_zero <= 1'b0;
          // zero divisor skips iteration and yields all-ones quotient, dividend remainder
          if (divisor == '0) begin
            dz_q  <= 1'b1;
            r_q   <= dividend;
            q_q   <= '1;
            state <= FIN;
          end else begin
            dz_q  <= 1'b0;
            r_q   <= '0;
            q_q   <= dividend;
            state <= RUN;
          end
        end
        RUN: begin
          r_q <= r_nxt;
          q_q <= {q_q[WIDTH-2:0], q_bit};
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIN;
        end
        FIN: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          quotient    <= q_q;
          remainder   <= r_q;
          div_by_zero <= dz_q;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
